// File: rtl/fmul_half_precision_pkg.sv
// Shared constants and the split-field half-precision type for the FP multiply leaf.
package fmul_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam int PROD_W = 2 * (MAN_W + 1);
  // Two extra bits give the biased exponent sum room for both sign and carry.
  localparam int ESUM_W = EXP_W + 2;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } half_t;

endpackage

// File: rtl/fmul_half_precision_if.sv
// Operand/result bundle of the half-precision multiplier; master drives operands, slave returns the product.
interface fmul_half_precision_if;

  logic                       in_Valid;
  logic                       in_Sign_1;
  logic [fmul_pkg::EXP_W-1:0] in_Exponent_1;
  logic [fmul_pkg::MAN_W-1:0] in_Mantissa_1;
  logic                       in_Sign_2;
  logic [fmul_pkg::EXP_W-1:0] in_Exponent_2;
  logic [fmul_pkg::MAN_W-1:0] in_Mantissa_2;

  logic                       out_Valid;
  logic                       out_Sign;
  logic [fmul_pkg::EXP_W-1:0] out_Exponent;
  logic [fmul_pkg::MAN_W-1:0] out_Mantissa;
  logic                       Exponent_Overflow;
  logic                       Exponent_Underflow;

  modport master (
    output in_Valid, in_Sign_1, in_Exponent_1, in_Mantissa_1,
           in_Sign_2, in_Exponent_2, in_Mantissa_2,
    input  out_Valid, out_Sign, out_Exponent, out_Mantissa,
           Exponent_Overflow, Exponent_Underflow
  );

  modport slave (
    input  in_Valid, in_Sign_1, in_Exponent_1, in_Mantissa_1,
           in_Sign_2, in_Exponent_2, in_Mantissa_2,
    output out_Valid, out_Sign, out_Exponent, out_Mantissa,
           Exponent_Overflow, Exponent_Underflow
  );

endinterface

// File: rtl/fmul_half_precision_mant_mult.sv
// Combinational 11x11 unsigned significand multiplier (hidden bit included by the caller).
module fmul_mant_mult
  import fmul_pkg::*;
(
  input  logic [MAN_W:0]    a_i,
  input  logic [MAN_W:0]    b_i,
  output logic [PROD_W-1:0] prod_o
);

  assign prod_o = a_i * b_i;

endmodule

// File: rtl/fmul_half_precision.sv
// Two-stage binary16 multiplier: stage 1 forms sign/exponent sum/significand product,
// stage 2 normalizes, truncates and selects zero, infinity or underflow results.
module fmul_half_precision
  import fmul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fmul_half_precision_if.slave  bus
);

  localparam logic signed [ESUM_W-1:0] E_MAX_S = ESUM_W'(EXP_MAX);
  localparam logic signed [ESUM_W-1:0] E_ONE_S = ESUM_W'(1);

  // Stage 1 combinational terms.
  logic                     sign_d;
  logic                     zero_d;
  logic signed [ESUM_W-1:0] esum_d;
  logic [PROD_W-1:0]        prod_d;

  logic                     s1_valid_q;
  logic                     s1_sign_q;
  logic                     s1_zero_q;
  logic signed [ESUM_W-1:0] s1_esum_q;
  logic [PROD_W-1:0]        s1_prod_q;

  assign sign_d = bus.in_Sign_1 ^ bus.in_Sign_2;
  // Subnormal inputs are flushed: any zero exponent field forces a signed zero result.
  assign zero_d = (bus.in_Exponent_1 == '0) | (bus.in_Exponent_2 == '0);
  assign esum_d = $signed({2'b00, bus.in_Exponent_1} + {2'b00, bus.in_Exponent_2}
                          - ESUM_W'(BIAS));

  fmul_mant_mult u_mant_mult (
    .a_i    ({1'b1, bus.in_Mantissa_1}),
    .b_i    ({1'b1, bus.in_Mantissa_2}),
    .prod_o (prod_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_esum_q  <= '0;
      s1_prod_q  <= '0;
    end else begin
      s1_valid_q <= bus.in_Valid;
      if (bus.in_Valid) begin
        s1_sign_q <= sign_d;
        s1_zero_q <= zero_d;
        s1_esum_q <= esum_d;
        s1_prod_q <= prod_d;
      end
    end
  end

  // Stage 2: normalize (product of two [1,2) significands lies in [1,4)) and select.
  logic signed [ESUM_W-1:0] e_norm;
  logic [MAN_W-1:0]         m_norm;
  half_t                    res_d;
  logic                     ovf_d;
  logic                     unf_d;

  assign e_norm = s1_prod_q[PROD_W-1] ? s1_esum_q + E_ONE_S : s1_esum_q;
  assign m_norm = s1_prod_q[PROD_W-1] ? s1_prod_q[PROD_W-2:MAN_W+1]
                                      : s1_prod_q[PROD_W-3:MAN_W];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_d      = '0;
    res_d.sign = s1_sign_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    if (s1_zero_q) begin
      res_d.exp = '0;
    end else if (e_norm >= E_MAX_S) begin
      res_d.exp = '1;
      ovf_d     = 1'b1;
    end else if (e_norm < E_ONE_S) begin
      unf_d = 1'b1;
    end else begin
      res_d.exp = e_norm[EXP_W-1:0];
      res_d.man = m_norm;
    end
  end

  half_t out_q;
  logic  valid_q;
  logic  ovf_q;
  logic  unf_q;

  // Result fields only move with a valid stage-1 entry, so they hold between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

  assign bus.out_Valid          = valid_q;
  assign bus.out_Sign           = out_q.sign;
  assign bus.out_Exponent       = out_q.exp;
  assign bus.out_Mantissa       = out_q.man;
  assign bus.Exponent_Overflow  = ovf_q;
  assign bus.Exponent_Underflow = unf_q;

endmodule

// File: tb/tb_fmul_half_precision.sv
// Directed and randomized bench for the half-precision multiplier with a latency-aware scoreboard.
module tb_fmul_half_precision;
  import fmul_pkg::*;

  typedef struct {
    half_t res;
    logic  ovf;
    logic  unf;
    int    due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmul_half_precision_if bus ();

  fmul_half_precision dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t last;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic half_t h(logic s, logic [4:0] e, logic [9:0] m);
    half_t r;
    r.sign = s;
    r.exp  = e;
    r.man  = m;
    return r;
  endfunction

  function automatic exp_t mk_exp(half_t r, logic o, logic u);
    exp_t x;
    x.res = r;
    x.ovf = o;
    x.unf = u;
    x.due = 0;
    return x;
  endfunction

  // Reference model: integer arithmetic on the real significands.
  function automatic exp_t model(half_t a, half_t b);
    int   p;
    int   e;
    exp_t x;
    x = mk_exp(h(a.sign ^ b.sign, 5'd0, 10'd0), 1'b0, 1'b0);
    if (a.exp == 0 || b.exp == 0) return x;
    p = (1024 + int'(a.man)) * (1024 + int'(b.man));
    e = int'(a.exp) + int'(b.exp) - 15;
    if (p >= (1 << 21)) begin
      p = p / 2048;
      e = e + 1;
    end else begin
      p = p / 1024;
    end
    if (e >= 31) begin
      x.res.exp = 5'h1f;
      x.ovf     = 1'b1;
    end else if (e <= 0) begin
      x.unf = 1'b1;
    end else begin
      x.res.exp = e[4:0];
      x.res.man = p[9:0];
    end
    return x;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    logic want;
    @(posedge clk);
    #1;
    cyc++;
    want = (sb.size() > 0) && (sb[0].due == cyc);
    check("out_valid", 32'(bus.out_Valid), 32'(want));
    if (want) last = sb.pop_front();
    check("result", 32'({bus.out_Sign, bus.out_Exponent, bus.out_Mantissa}), 32'(last.res));
    check("flags", 32'({bus.Exponent_Overflow, bus.Exponent_Underflow}), 32'({last.ovf, last.unf}));
  endtask

  task automatic drive(logic v, half_t a, half_t b, exp_t x);
    bus.in_Valid      = v;
    bus.in_Sign_1     = a.sign;
    bus.in_Exponent_1 = a.exp;
    bus.in_Mantissa_1 = a.man;
    bus.in_Sign_2     = b.sign;
    bus.in_Exponent_2 = b.exp;
    bus.in_Mantissa_2 = b.man;
    if (v) begin
      x.due = cyc + 2;
      sb.push_back(x);
    end
    tick();
  endtask

  task automatic drive_model(half_t a, half_t b);
    drive(1'b1, a, b, model(a, b));
  endtask

  task automatic idle();
    half_t g1;
    half_t g2;
    g1 = half_t'($urandom);
    g2 = half_t'($urandom);
    drive(1'b0, g1, g2, mk_exp(h(0, 0, 0), 0, 0));
  endtask

  task automatic check_all_zero(string tag);
    check(tag, 32'({bus.out_Valid, bus.out_Sign, bus.out_Exponent, bus.out_Mantissa,
                    bus.Exponent_Overflow, bus.Exponent_Underflow}), 32'd0);
  endtask

  initial begin
    half_t a;
    half_t b;
    last = mk_exp(h(0, 0, 0), 0, 0);
    bus.in_Valid      = 1'b1;
    bus.in_Sign_1     = 1'b1;
    bus.in_Exponent_1 = 5'd15;
    bus.in_Mantissa_1 = 10'd3;
    bus.in_Sign_2     = 1'b0;
    bus.in_Exponent_2 = 5'd15;
    bus.in_Mantissa_2 = 10'd3;

    // Reset held across a clock edge with valid operands present.
    #7;
    check_all_zero("reset_state");
    #5;
    rst = 1'b0;

    // Directed cases, issued back to back.
    drive(1'b1, h(1, 5'd0, 10'd0), h(0, 5'b11010, 10'b0101010000),
          mk_exp(h(1, 5'd0, 10'd0), 1'b0, 1'b0));
    drive(1'b1, h(0, 5'd15, 10'd0), h(0, 5'd15, 10'd0),
          mk_exp(h(0, 5'd15, 10'd0), 1'b0, 1'b0));
    drive(1'b1, h(0, 5'd15, 10'b1000000000), h(1, 5'd15, 10'b1000000000),
          mk_exp(h(1, 5'd16, 10'b0010000000), 1'b0, 1'b0));
    drive(1'b1, h(0, 5'd30, 10'd0), h(0, 5'd30, 10'd0),
          mk_exp(h(0, 5'd31, 10'd0), 1'b1, 1'b0));
    drive(1'b1, h(0, 5'd1, 10'd0), h(1, 5'd1, 10'd0),
          mk_exp(h(1, 5'd0, 10'd0), 1'b0, 1'b1));
    // Truncation of the largest significand product: 1.9990234375^2 -> 1.998046875 x 2.
    drive(1'b1, h(0, 5'd15, 10'h3ff), h(0, 5'd15, 10'h3ff),
          mk_exp(h(0, 5'd16, 10'b1111111110), 1'b0, 1'b0));
    idle();

    // Exponent boundaries, normalize-driven overflow, exponent-31 input, zero priority.
    drive_model(h(0, 5'd15, 10'd0),   h(0, 5'd30, 10'd0));
    drive_model(h(1, 5'd16, 10'd0),   h(0, 5'd30, 10'd0));
    drive_model(h(0, 5'd7, 10'd0),    h(0, 5'd8, 10'd0));
    drive_model(h(0, 5'd8, 10'd0),    h(1, 5'd8, 10'd0));
    drive_model(h(0, 5'd15, 10'd512), h(0, 5'd30, 10'd512));
    drive_model(h(0, 5'd7, 10'd512),  h(0, 5'd8, 10'd512));
    drive_model(h(0, 5'd31, 10'd100), h(0, 5'd1, 10'd200));
    drive_model(h(1, 5'd0, 10'd5),    h(1, 5'd31, 10'd7));
    idle();

    for (int i = 0; i < 40; i++) begin
      a = half_t'($urandom);
      b = half_t'($urandom);
      if ((i % 5) == 4) idle();
      drive_model(a, b);
    end
    idle();
    idle();
    idle();

    // Async reset between edges with one result visible and one still in flight.
    drive(1'b1, h(0, 5'd15, 10'd0), h(0, 5'd15, 10'd0),
          mk_exp(h(0, 5'd15, 10'd0), 1'b0, 1'b0));
    drive(1'b1, h(0, 5'd20, 10'd100), h(0, 5'd16, 10'd3),
          mk_exp(h(0, 5'd0, 10'd0), 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    last = mk_exp(h(0, 0, 0), 0, 0);
    #2;
    rst = 1'b0;
    idle();
    idle();
    idle();
    drive_model(h(1, 5'd18, 10'd321), h(0, 5'd12, 10'd777));
    idle();
    idle();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
